// File: rtl/fifo_push_arb.sv
// Round-robin arbiter that shares one fifo push port among NREQ requesters through a one-entry stage.
// Define FIFO_ARB_STATS_EN to add per-requester saturating grant counters (clr_i, gnt_cnt_o).
module fifo_push_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
`ifdef FIFO_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  push_o,
    output logic [WIDTH-1:0]      push_data_o,
    input  logic                  full_i
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                  clr_i,
    output logic [NREQ*CNT_W-1:0] gnt_cnt_o
`endif
);

    localparam int PTR_W = $clog2(NREQ);

    logic                 vld_reg;
    logic [WIDTH-1:0]     data_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic [PTR_W-1:0]     ptr_next;

    logic                 accept;
    logic                 drain;
    logic                 any_gnt;
    logic [NREQ-1:0]      gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W:0]       pos;
    logic [WIDTH-1:0]     word_arr [NREQ];

    genvar gi;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_word
            assign word_arr[gi] = data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The stage can take a word if it is empty or is being pushed into the fifo this cycle.
    assign drain  = vld_reg && !full_i;
    assign accept = !vld_reg || !full_i;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        pos     = '0;
        if (accept && !rst_i) begin
            for (int k = 0; k < NREQ; k++) begin
                pos = {1'b0, ptr_reg} + (PTR_W+1)'(k);
                if (pos >= (PTR_W+1)'(NREQ)) begin
                    pos = pos - (PTR_W+1)'(NREQ);
                end
                if (!any_gnt && req_i[pos[PTR_W-1:0]]) begin
                    any_gnt                = 1'b1;
                    gnt_idx                = pos[PTR_W-1:0];
                    gnt[pos[PTR_W-1:0]]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_next = gnt_idx + PTR_W'(1);
        if (gnt_idx == PTR_W'(NREQ-1)) begin
            ptr_next = '0;
        end
    end

    // Priority only moves on a grant, so a blocked fifo never reshuffles the order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_reg  <= 1'b0;
            data_reg <= '0;
            ptr_reg  <= '0;
        end else if (any_gnt) begin
            vld_reg  <= 1'b1;
            data_reg <= word_arr[gnt_idx];
            ptr_reg  <= ptr_next;
        end else if (drain) begin
            vld_reg  <= 1'b0;
        end
    end

    assign gnt_o       = gnt;
    assign push_o      = vld_reg;
    assign push_data_o = data_reg;

`ifdef FIFO_ARB_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Clear wins over a same-cycle grant; counts stick at all-ones.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else if (clr_i) begin
                    cnt_reg <= '0;
                end else if (gnt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign gnt_cnt_o[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: a 16-deep fifo model, a behavioural arbiter model and a word scoreboard.
// Build with FIFO_ARB_STATS_EN defined to also cover the grant counters (CNT_W=3).
module tb_fifo_push_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
`ifdef FIFO_ARB_STATS_EN
    localparam int CNT_W = 3;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] data_i;
    logic [NREQ-1:0]       gnt_o;
    logic                  push_o;
    logic [WIDTH-1:0]      push_data_o;
    logic                  full_i;
`ifdef FIFO_ARB_STATS_EN
    logic                  clr_i;
    logic [NREQ*CNT_W-1:0] gnt_cnt_o;
`endif

    fifo_push_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
`ifdef FIFO_ARB_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .push_o      (push_o),
        .push_data_o (push_data_o),
        .full_i      (full_i)
`ifdef FIFO_ARB_STATS_EN
        ,
        .clr_i       (clr_i),
        .gnt_cnt_o   (gnt_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] sb_q   [$];

    logic [NREQ-1:0]  req_b;
    logic [WIDTH-1:0] data_b [NREQ];
    bit               drop_on_gnt;
    bit               pop_en;
    bit               clr_b;

    logic             m_vld;
    logic [WIDTH-1:0] m_data;
    int               m_ptr;
    int               m_cnt [NREQ];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic run_cycle();
        logic [NREQ-1:0]  eg;
        int               er;
        int               idx;
        logic             full_s;
        logic             push_s;
        logic [WIDTH-1:0] pd_s;
        logic [WIDTH-1:0] w;
        for (int r = 0; r < NREQ; r++) data_i[r*WIDTH +: WIDTH] = data_b[r];
        req_i  = req_b;
        full_i = (fifo_q.size() >= DEPTH);
`ifdef FIFO_ARB_STATS_EN
        clr_i  = clr_b;
`endif
        #1;
        eg = '0;
        er = -1;
        if (!m_vld || !full_i) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (er < 0 && req_b[idx]) er = idx;
            end
        end
        if (er >= 0) eg[er] = 1'b1;
        check_val("gnt", 64'(gnt_o), 64'(eg));
        check_val("push", 64'(push_o), 64'(m_vld));
        if (m_vld) check_val("push_data", 64'(push_data_o), 64'(m_data));
`ifdef FIFO_ARB_STATS_EN
        for (int r = 0; r < NREQ; r++)
            check_val("gnt_cnt", 64'(gnt_cnt_o[r*CNT_W +: CNT_W]), 64'(m_cnt[r]));
`endif
        full_s = full_i;
        push_s = push_o;
        pd_s   = push_data_o;
        @(posedge clk_i);
        if (pop_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            check_val("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
            if (sb_q.size() > 0) check_val("pop_word", 64'(w), 64'(sb_q.pop_front()));
            $display("pop  word=%0d", w);
        end
        if (push_s && !full_s) fifo_q.push_back(pd_s);
        if (er >= 0) begin
            sb_q.push_back(data_b[er]);
            m_vld  = 1'b1;
            m_data = data_b[er];
            m_ptr  = (er + 1) % NREQ;
            if (drop_on_gnt) req_b[er] = 1'b0;
            $display("gnt  req=%0d word=%0d", er, data_b[er]);
        end else if (m_vld && !full_s) begin
            m_vld = 1'b0;
        end
        if (clr_b) begin
            for (int r = 0; r < NREQ; r++) m_cnt[r] = 0;
        end else if (er >= 0 && m_cnt[er] < 7) begin
            m_cnt[er]++;
        end
        @(negedge clk_i);
    endtask

    task automatic drain_all();
        req_b  = '0;
        pop_en = 1'b1;
        for (int i = 0; i < 60 && (fifo_q.size() > 0 || m_vld); i++) run_cycle();
        pop_en = 1'b0;
        check_val("drained", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        req_i       = '1;
        data_i      = '0;
        full_i      = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        clr_i       = 1'b0;
`endif
        req_b       = '0;
        drop_on_gnt = 1'b1;
        pop_en      = 1'b0;
        clr_b       = 1'b0;
        m_vld       = 1'b0;
        m_data      = '0;
        m_ptr       = 0;
        for (int r = 0; r < NREQ; r++) begin
            data_b[r] = '0;
            m_cnt[r]  = 0;
        end
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("rst_gnt", 64'(gnt_o), 64'(0));
        check_val("rst_push", 64'(push_o), 64'(0));
        check_val("rst_data", 64'(push_data_o), 64'(0));
        rst_i = 1'b0;

        // Single request: same-cycle grant, push next cycle, idle after.
        req_b = 4'b0001; data_b[0] = 10;
        run_cycle();
        run_cycle();
        run_cycle();

        // All requesting with held requests: rotation 0,1,2,3,0,...
        drop_on_gnt = 1'b0;
        for (int r = 0; r < NREQ; r++) data_b[r] = 100 + r;
        req_b = 4'b1111;
        repeat (8) run_cycle();
        drain_all();

        // Fill the fifo, then stage one word behind the full fifo.
        drop_on_gnt = 1'b1;
        for (int n = 0; n < 40 && (fifo_q.size() + int'(m_vld)) < DEPTH; n++) begin
            req_b = 4'b0001; data_b[0] = 200 + n;
            run_cycle();
        end
        req_b = '0;
        run_cycle();
        check_val("fill_level", 64'(fifo_q.size()), 64'(DEPTH));
        req_b = 4'b0100; data_b[2] = 55;
        run_cycle();
        req_b = 4'b0010; data_b[1] = 77;
        repeat (3) run_cycle();
        pop_en = 1'b1;
        run_cycle();
        pop_en = 1'b0;
        run_cycle();
        check_val("extra_level", 64'(fifo_q.size()), 64'(DEPTH));
        check_val("extra_word", 64'(fifo_q[$]), 64'(55));
        run_cycle();
        drain_all();

        // Back-to-back: drain and reload in the same cycle, no bubble.
        req_b = 4'b0001; data_b[0] = 400;
        run_cycle();
        req_b = 4'b0010; data_b[1] = 401;
        run_cycle();
        run_cycle();
        drain_all();

        // Reset while a word is staged.
        drop_on_gnt = 1'b0;
        for (int r = 0; r < NREQ; r++) data_b[r] = 500 + r;
        req_b  = 4'b1111;
        pop_en = 1'b1;
        run_cycle();
        run_cycle();
        req_i = 4'b1111;
        rst_i = 1'b1;
        #1;
        check_val("midrst_push", 64'(push_o), 64'(0));
        check_val("midrst_gnt", 64'(gnt_o), 64'(0));
        if (m_vld) void'(sb_q.pop_back());
        m_vld = 1'b0;
        m_ptr = 0;
        for (int r = 0; r < NREQ; r++) m_cnt[r] = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_cycle();
        check_val("post_rst_first", 64'(m_data), 64'(500));
        drain_all();

`ifdef FIFO_ARB_STATS_EN
        // Counter saturation, clear, and clear overriding a same-cycle grant.
        drop_on_gnt = 1'b0;
        pop_en      = 1'b1;
        req_b       = 4'b0100; data_b[2] = 600;
        repeat (8) run_cycle();
        req_b = '0;
        run_cycle();
        clr_b = 1'b1;
        run_cycle();
        clr_b = 1'b0;
        run_cycle();
        req_b = 4'b0100;
        clr_b = 1'b1;
        run_cycle();
        clr_b = 1'b0;
        req_b = '0;
        run_cycle();
        drain_all();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
